// File: rtl/decode_mux_unit_if.sv
// Purpose: bundles the decoder and read-mux signals of decode_mux_unit.
//   i_dec_sel/i_dec_en   decoder index and enable
//   o_dec_comb/o_dec_q   combinational and registered one-hot enables
//   i_mux_in[0..15]      read-mux data inputs (entry 0 picked by select 0)
//   i_mux_sel            read-mux select
//   o_mux_comb/o_mux_q   combinational and registered selected data
interface decode_mux_unit_if #(
   parameter int unsigned WIDTH = 16
);
   logic [3:0]             i_dec_sel;
   logic                   i_dec_en;
   logic [15:0]            o_dec_comb;
   logic [15:0]            o_dec_q;
   logic [15:0][WIDTH-1:0] i_mux_in;
   logic [3:0]             i_mux_sel;
   logic [WIDTH-1:0]       o_mux_comb;
   logic [WIDTH-1:0]       o_mux_q;

   // Driver side (register-file control / bench)
   modport master (
      output i_dec_sel, i_dec_en, i_mux_in, i_mux_sel,
      input  o_dec_comb, o_dec_q, o_mux_comb, o_mux_q
   );

   // Decode/mux block side
   modport slave (
      input  i_dec_sel, i_dec_en, i_mux_in, i_mux_sel,
      output o_dec_comb, o_dec_q, o_mux_comb, o_mux_q
   );
endinterface

// File: rtl/decode_mux_unit.sv
// Purpose: register-file support block - 4-to-16 one-hot write decoder and a
//   16-way read mux, each offered combinationally and as a 1-cycle registered copy.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (clears registered outputs)
//   bus      decode_mux_unit_if.slave carrying selects, data and results
module decode_mux_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   decode_mux_unit_if.slave   bus
);

   localparam int unsigned NUM_REGS = 16;

   logic [NUM_REGS-1:0] w_dec;
   logic [WIDTH-1:0]    w_mux;
   logic [NUM_REGS-1:0] r_dec_q;
   logic [WIDTH-1:0]    r_mux_q;

   // One-hot write decoder; disabled decoder drives no enables
   always_comb begin
      w_dec = '0;
      if (bus.i_dec_en) begin
         w_dec = NUM_REGS'(1) << bus.i_dec_sel;
      end
   end

   // Read mux: every select code maps to an input, so no hold path exists
   always_comb begin
      w_mux = '0;
      case (bus.i_mux_sel)
         4'd0:  w_mux = bus.i_mux_in[0];
         4'd1:  w_mux = bus.i_mux_in[1];
         4'd2:  w_mux = bus.i_mux_in[2];
         4'd3:  w_mux = bus.i_mux_in[3];
         4'd4:  w_mux = bus.i_mux_in[4];
         4'd5:  w_mux = bus.i_mux_in[5];
         4'd6:  w_mux = bus.i_mux_in[6];
         4'd7:  w_mux = bus.i_mux_in[7];
         4'd8:  w_mux = bus.i_mux_in[8];
         4'd9:  w_mux = bus.i_mux_in[9];
         4'd10: w_mux = bus.i_mux_in[10];
         4'd11: w_mux = bus.i_mux_in[11];
         4'd12: w_mux = bus.i_mux_in[12];
         4'd13: w_mux = bus.i_mux_in[13];
         4'd14: w_mux = bus.i_mux_in[14];
         4'd15: w_mux = bus.i_mux_in[15];
         default: w_mux = '0;
      endcase
   end

   // Registered copies, captured every cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dec_q <= '0;
         r_mux_q <= '0;
      end else begin
         r_dec_q <= w_dec;
         r_mux_q <= w_mux;
      end
   end

   assign bus.o_dec_comb = w_dec;
   assign bus.o_mux_comb = w_mux;
   assign bus.o_dec_q    = r_dec_q;
   assign bus.o_mux_q    = r_mux_q;

endmodule

// File: tb/tb_decode_mux_unit.sv
// Directed bench for decode_mux_unit: reset, decode/mux sweeps, enable low,
// mid-cycle async reset and mid-cycle input glitch.
module tb_decode_mux_unit;

   localparam int unsigned WIDTH = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   decode_mux_unit_if #(.WIDTH(WIDTH)) bus ();

   decode_mux_unit #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] exp_v;
      checks = 0;
      errors = 0;

      // Step 1: reset held while clock runs
      rst_n         = 1'b0;
      bus.i_dec_sel = 4'd3;
      bus.i_dec_en  = 1'b1;
      bus.i_mux_sel = 4'd0;
      for (int n = 0; n < 16; n++) bus.i_mux_in[n] = 16'hA000 + 16'(n);
      #1;
      chk("rst_dec_comb", bus.o_dec_comb, 16'h0008);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("rst_dec_q", bus.o_dec_q, 16'h0000);
         chk("rst_mux_q", bus.o_mux_q, 16'h0000);
      end
      rst_n = 1'b1;

      // Step 2: decode sweep
      for (int s = 0; s < 16; s++) begin
         bus.i_dec_sel = 4'(s);
         exp_v = 16'h0001 << s;
         #1;
         chk("dec_comb_sweep", bus.o_dec_comb, exp_v);
         @(posedge clk); #1;
         chk("dec_q_sweep", bus.o_dec_q, exp_v);
      end
      chk("dec_q_sel15", bus.o_dec_q, 16'h8000);

      // Step 3: enable low
      bus.i_dec_en  = 1'b0;
      bus.i_dec_sel = 4'd7;
      #1;
      chk("dec_comb_en0", bus.o_dec_comb, 16'h0000);
      @(posedge clk); #1;
      chk("dec_q_en0", bus.o_dec_q, 16'h0000);

      // Step 4: mux sweep
      for (int s = 0; s < 16; s++) begin
         bus.i_mux_sel = 4'(s);
         exp_v = 16'hA000 + 16'(s);
         #1;
         chk("mux_comb_sweep", bus.o_mux_comb, exp_v);
         @(posedge clk); #1;
         chk("mux_q_sweep", bus.o_mux_q, exp_v);
      end
      chk("mux_q_sel15", bus.o_mux_q, 16'hA00F);

      // Step 5: async reset pulse between edges
      bus.i_mux_sel = 4'd5;
      bus.i_dec_en  = 1'b1;
      bus.i_dec_sel = 4'd2;
      @(posedge clk); #1;
      chk("pre_rst_mux_q", bus.o_mux_q, 16'hA005);
      chk("pre_rst_dec_q", bus.o_dec_q, 16'h0004);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_mux_q", bus.o_mux_q, 16'h0000);
      chk("mid_rst_dec_q", bus.o_dec_q, 16'h0000);
      chk("mid_rst_mux_comb", bus.o_mux_comb, 16'hA005);
      #2 rst_n = 1'b1;
      #1;
      chk("post_rel_mux_q", bus.o_mux_q, 16'h0000);
      @(posedge clk); #1;
      chk("resume_mux_q", bus.o_mux_q, 16'hA005);
      chk("resume_dec_q", bus.o_dec_q, 16'h0004);

      // Step 6: mid-cycle glitch on the selected input
      bus.i_mux_in[5] = 16'h1234;
      @(posedge clk); #1;
      chk("glitch_base_q", bus.o_mux_q, 16'h1234);
      #2 bus.i_mux_in[5] = 16'h5678;
      #1;
      chk("glitch_comb_hi", bus.o_mux_comb, 16'h5678);
      chk("glitch_q_held", bus.o_mux_q, 16'h1234);
      #2 bus.i_mux_in[5] = 16'h1234;
      #1;
      chk("glitch_comb_back", bus.o_mux_comb, 16'h1234);
      @(posedge clk); #1;
      chk("glitch_q_edge", bus.o_mux_q, 16'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
